binary_to_bcd: RTL and testbench

Parametrised sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock) with valid/ready handshakes on both sides. It supports optional signed (two's-complement) input, and reports a sign flag and significant-digit count for leading-zero blanking. It sits between arithmetic/datapath blocks and 7-segment or UART display drivers, and generalises the fixed 32-bit unsigned converter to any width.

---
 rtl/bcd_pkg.sv | 8 +
 rtl/bcd_digit_adjust.sv | 15 +
 rtl/binary_to_bcd.sv | 87 ++++++++
 tb/tb_binary_to_bcd.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared state encoding, digit-count helper and add-3 threshold for BCD converters
package bcd_pkg;
    typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_DONE} bcd_state_t;
    localparam int BCD_ADD_THRESH = 5;
    function automatic int bcd_digits(input int width);
        return (width * 301) / 1000 + 1;
    endfunction
endpackage

// File: rtl/bcd_digit_adjust.sv
// bcd_digit_adjust: per-nibble add-3 correction (nibbles >= 5 gain 3, no inter-nibble carry)
// Ports: bcd_in - packed BCD before correction; bcd_out - corrected packed BCD
module bcd_digit_adjust
    import bcd_pkg::*;
#(
    parameter int DIGITS = 10
) (
    input  logic [4*DIGITS-1:0] bcd_in,
    output logic [4*DIGITS-1:0] bcd_out
);
    genvar d;
    for (d = 0; d < DIGITS; d++) begin : g_dig
        assign bcd_out[4*d +: 4] = (bcd_in[4*d +: 4] >= 4'(BCD_ADD_THRESH)) ? bcd_in[4*d +: 4] + 4'd3 : bcd_in[4*d +: 4];
    end
endmodule

// File: rtl/binary_to_bcd.sv
// binary_to_bcd: sequential shift-and-add-3 binary to BCD converter with valid/ready on both sides
// Ports: clk/reset (sync, active-high); in_valid/in_ready/in_data/in_signed operand side;
//        out_valid/out_ready result side with out_bcd (digit 0 in [3:0]), out_neg and
//        out_digits (significant digit count, 1 for zero)
module binary_to_bcd
    import bcd_pkg::*;
#(
    parameter  int WIDTH  = 32,
    localparam int DIGITS = bcd_digits(WIDTH),
    localparam int DW     = $clog2(DIGITS + 1),
    localparam int CW     = $clog2(WIDTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_data,
    input  logic                in_signed,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] out_bcd,
    output logic                out_neg,
    output logic [DW-1:0]       out_digits
);
    bcd_state_t          state, state_next;
    logic [CW-1:0]       cnt;
    logic [WIDTH-1:0]    mag;
    logic [4*DIGITS-1:0] sr, adj, shifted;
    logic                neg_r, neg_in, last;
    logic [DW-1:0]       dig_cnt;

    bcd_digit_adjust #(.DIGITS(DIGITS)) u_adjust (.bcd_in(sr), .bcd_out(adj));

    assign in_ready  = state == S_IDLE;
    assign out_valid = state == S_DONE;
    assign neg_in    = in_signed && in_data[WIDTH-1];
    assign last      = cnt == CW'(WIDTH - 1);
    // shift the corrected register left, pulling in the magnitude MSB
    assign shifted   = (adj << 1) | {{(4*DIGITS-1){1'b0}}, mag[WIDTH-1]};

    // last nonzero digit found wins, i.e. the most significant one
    always_comb begin
        dig_cnt = DW'(1);
        for (int i = 0; i < DIGITS; i++)
            if (shifted[4*i +: 4] != 4'd0) dig_cnt = DW'(i + 1);
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    state_next = in_valid ? S_CONVERT : S_IDLE;
            S_CONVERT: state_next = last ? S_DONE : S_CONVERT;
            S_DONE:    state_next = out_ready ? S_IDLE : S_DONE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk)
        state <= reset ? S_IDLE : state_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            mag        <= '0;
            sr         <= '0;
            neg_r      <= 1'b0;
            out_bcd    <= '0;
            out_neg    <= 1'b0;
            out_digits <= DW'(1);
        end else if (state == S_IDLE && in_valid) begin
            // negation in WIDTH bits maps -2^(WIDTH-1) onto its correct unsigned magnitude
            mag   <= neg_in ? -in_data : in_data;
            neg_r <= neg_in;
            sr    <= '0;
            cnt   <= '0;
        end else if (state == S_CONVERT) begin
            sr  <= shifted;
            mag <= mag << 1;
            cnt <= cnt + 1'b1;
            if (last) begin
                out_bcd    <= shifted;
                out_neg    <= neg_r;
                out_digits <= dig_cnt;
            end
        end
    end
endmodule

// File: tb/tb_binary_to_bcd.sv
// tb_binary_to_bcd: scoreboard bench for 32-bit and 8-bit converter instances
module tb_binary_to_bcd;
    logic clk = 1'b0, reset = 1'b1;
    always #5 clk = ~clk;

    logic        iv32 = 0, is32 = 0, or32 = 1, ir32, ov32, on32;
    logic [31:0] id32 = '0;
    logic [39:0] ob32;
    logic [3:0]  od32;
    logic        iv8 = 0, is8 = 0, or8 = 1, ir8, ov8, on8;
    logic [7:0]  id8 = '0;
    logic [11:0] ob8;
    logic [1:0]  od8;

    binary_to_bcd #(.WIDTH(32)) u32 (
        .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir32), .in_data(id32),
        .in_signed(is32), .out_valid(ov32), .out_ready(or32), .out_bcd(ob32),
        .out_neg(on32), .out_digits(od32)
    );
    binary_to_bcd #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8), .in_data(id8),
        .in_signed(is8), .out_valid(ov8), .out_ready(or8), .out_bcd(ob8),
        .out_neg(on8), .out_digits(od8)
    );

    typedef struct packed {
        logic [39:0] bcd;
        logic        neg;
        logic [3:0]  dig;
    } exp_t;

    exp_t q32[$], q8[$];
    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset) begin
            chk("excl32", {63'd0, ov32 && ir32}, 64'd0);
            chk("excl8", {63'd0, ov8 && ir8}, 64'd0);
            if (ov32 && or32) begin
                if (q32.size() == 0) chk("unexpected32", 64'd1, 64'd0);
                else begin
                    e = q32.pop_front();
                    chk("bcd32", ob32, e.bcd);
                    chk("neg32", on32, e.neg);
                    chk("dig32", od32, e.dig);
                end
            end
            if (ov8 && or8) begin
                if (q8.size() == 0) chk("unexpected8", 64'd1, 64'd0);
                else begin
                    e = q8.pop_front();
                    chk("bcd8", ob8, e.bcd);
                    chk("neg8", on8, e.neg);
                    chk("dig8", od8, e.dig);
                end
            end
        end
    end

    task automatic conv32(input logic [31:0] d, input logic s, input logic [39:0] eb,
                          input logic en, input logic [3:0] ed);
        int k;
        chk("ready32", ir32, 1);
        iv32 = 1; id32 = d; is32 = s;
        tick();
        q32.push_back(exp_t'{bcd: eb, neg: en, dig: ed});
        iv32 = 0; id32 = ~d; is32 = ~s;
        k = 0;
        do begin tick(); k++; end while (!ov32 && k < 200);
        chk("lat32", k, 32);
        tick();
        chk("ready_after32", ir32, 1);
        chk("valid_after32", ov32, 0);
    endtask

    task automatic conv8(input logic [7:0] d, input logic s, input logic [11:0] eb,
                         input logic en, input logic [3:0] ed);
        int k;
        chk("ready8", ir8, 1);
        iv8 = 1; id8 = d; is8 = s;
        tick();
        q8.push_back(exp_t'{bcd: {28'd0, eb}, neg: en, dig: ed});
        iv8 = 0; id8 = ~d; is8 = ~s;
        k = 0;
        do begin tick(); k++; end while (!ov8 && k < 200);
        chk("lat8", k, 8);
        tick();
        chk("ready_after8", ir8, 1);
    endtask

    initial begin
        int k;
        tick();
        tick();
        chk("rst_ready32", ir32, 1);
        chk("rst_valid32", ov32, 0);
        chk("rst_bcd32", ob32, 0);
        chk("rst_neg32", on32, 0);
        chk("rst_dig32", od32, 1);
        chk("rst_dig8", od8, 1);
        reset = 0;
        tick();

        conv32(32'd0, 0, 40'h0, 0, 4'd1);
        conv32(32'hFFFF_FFFF, 0, 40'h42_9496_7295, 0, 4'd10);
        conv32(32'hFFFF_FFFF, 1, 40'h1, 1, 4'd1);
        conv32(32'h8000_0000, 1, 40'h21_4748_3648, 1, 4'd10);
        conv32(32'h7FFF_FFFF, 1, 40'h21_4748_3647, 0, 4'd10);
        conv32(32'd1000, 0, 40'h1000, 0, 4'd4);
        conv32(32'hFFFF_FC18, 1, 40'h1000, 1, 4'd4);
        conv32(32'd0, 1, 40'h0, 0, 4'd1);

        // backpressure: result held while out_ready low, new operands ignored
        or32 = 0;
        iv32 = 1; id32 = 32'd99999; is32 = 0;
        tick();
        q32.push_back(exp_t'{bcd: 40'h9_9999, neg: 1'b0, dig: 4'd5});
        iv32 = 0;
        k = 0;
        do begin tick(); k++; end while (!ov32 && k < 200);
        chk("lat_bp", k, 32);
        for (int i = 0; i < 5; i++) begin
            iv32 = ~iv32; id32 = 32'h1234 + i; is32 = i[0];
            tick();
            chk("hold_valid", ov32, 1);
            chk("hold_ready", ir32, 0);
            chk("hold_bcd", ob32, 40'h9_9999);
            chk("hold_dig", od32, 5);
        end
        iv32 = 0; or32 = 1;
        tick();
        chk("bp_ready", ir32, 1);
        chk("bp_valid", ov32, 0);
        repeat (40) tick();

        // reset on the 10th conversion edge aborts; result must never appear
        iv32 = 1; id32 = 32'hFFFF_FFFF; is32 = 0;
        tick();
        iv32 = 0;
        repeat (9) tick();
        reset = 1;
        tick();
        reset = 0;
        chk("abort_valid", ov32, 0);
        chk("abort_ready", ir32, 1);
        repeat (40) tick();
        conv32(32'd12345, 0, 40'h00_0001_2345, 0, 4'd5);

        conv8(8'd255, 0, 12'h255, 0, 4'd3);
        conv8(8'h80, 1, 12'h128, 1, 4'd3);
        conv8(8'hFF, 1, 12'h001, 1, 4'd1);
        conv8(8'd9, 0, 12'h009, 0, 4'd1);
        conv8(8'd10, 0, 12'h010, 0, 4'd2);

        repeat (3) tick();
        chk("q32_drained", q32.size(), 0);
        chk("q8_drained", q8.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
